// File: rtl/bip_control_mc_pkg.sv
// Shared encodings for the BIP control unit: opcodes, datapath selects, FSM states, control word.
package bip_pkg;

  localparam logic [31:0] OP_HLT  = 32'd0;
  localparam logic [31:0] OP_STO  = 32'd1;
  localparam logic [31:0] OP_LD   = 32'd2;
  localparam logic [31:0] OP_LDI  = 32'd3;
  localparam logic [31:0] OP_ADD  = 32'd4;
  localparam logic [31:0] OP_ADDI = 32'd5;
  localparam logic [31:0] OP_SUB  = 32'd6;
  localparam logic [31:0] OP_SUBI = 32'd7;

  localparam logic [1:0] SEL_A_MEM = 2'b00;
  localparam logic [1:0] SEL_A_IMM = 2'b01;
  localparam logic [1:0] SEL_A_ALU = 2'b10;
  localparam logic       SEL_B_MEM = 1'b0;
  localparam logic       SEL_B_IMM = 1'b1;
  localparam logic       ALU_ADD   = 1'b0;
  localparam logic       ALU_SUB   = 1'b1;

  typedef enum logic [1:0] {
    ST_FETCH,
    ST_EXEC,
    ST_LOAD_WAIT,
    ST_HALT
  } state_t;

  typedef struct packed {
    logic       wr_acc;
    logic       wr_ram;
    logic       rd_ram;
    logic       illegal;
    logic [1:0] sel_a;
    logic       sel_b;
    logic       op;
  } ctrl_t;

endpackage

// File: rtl/bip_control_mc_if.sv
// Decode bus: the FSM presents an opcode, the decoder returns the matching control word.
interface bip_control_mc_if #(
  parameter int NB_OPCODE = 5
);
  import bip_pkg::*;

  logic [NB_OPCODE-1:0] opcode;
  ctrl_t                ctrl;

  modport master (output opcode, input ctrl);
  modport slave  (input opcode, output ctrl);
endinterface

// File: rtl/bip_control_mc_decoder.sv
// Purely combinational opcode -> control word map; HLT yields an all-zero word.
module bip_decoder
  import bip_pkg::*;
(
  bip_control_mc_if.slave dec
);

  always_comb begin
    dec.ctrl = '0;
    case (32'(dec.opcode))
      OP_HLT: begin
      end
      OP_STO: dec.ctrl.wr_ram = 1'b1;
      OP_LD:  dec.ctrl.rd_ram = 1'b1;
      OP_LDI: begin
        dec.ctrl.wr_acc = 1'b1;
        dec.ctrl.sel_a  = SEL_A_IMM;
      end
      OP_ADD, OP_ADDI, OP_SUB, OP_SUBI: begin
        dec.ctrl.wr_acc = 1'b1;
        dec.ctrl.sel_a  = SEL_A_ALU;
        dec.ctrl.sel_b  = (32'(dec.opcode) == OP_ADDI || 32'(dec.opcode) == OP_SUBI) ? SEL_B_IMM : SEL_B_MEM;
        dec.ctrl.op     = (32'(dec.opcode) == OP_SUB  || 32'(dec.opcode) == OP_SUBI) ? ALU_SUB   : ALU_ADD;
      end
      default: dec.ctrl.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/bip_control_mc.sv
// Multi-cycle BIP control unit: fetch/exec/load-wait/halt FSM with PC and IR.
// Optional 32-bit executed-instruction counter when BIP_CONTROL_MC_INSTR_CNT_EN is defined.
module bip_control_mc
  import bip_pkg::*;
#(
  parameter int NB_PC      = 11,
  parameter int NB_OPCODE  = 5,
  parameter int NB_OPERAND = 11,
  parameter int NB_DATA    = 16
) (
  input  logic                          i_clock,
  input  logic                          i_reset,
  input  logic                          i_enable,
  input  logic [NB_OPCODE+NB_OPERAND-1:0] i_instr,
  input  logic                          i_instr_valid,
  output logic [NB_PC-1:0]              o_pc,
  output logic                          o_instr_req,
  output logic [NB_DATA-1:0]            o_operand,
  output logic [1:0]                    o_sel_a,
  output logic                          o_sel_b,
  output logic                          o_op,
  output logic                          o_wr_acc,
  output logic                          o_wr_ram,
  output logic                          o_rd_ram,
  output logic                          o_halt,
  output logic                          o_illegal
`ifdef BIP_CONTROL_MC_INSTR_CNT_EN
  ,
  output logic [31:0]                   o_instr_count
`endif
);

  localparam int NB_INSTR = NB_OPCODE + NB_OPERAND;

  state_t              state;
  logic [NB_PC-1:0]    pc;
  logic [NB_INSTR-1:0] ir;
  ctrl_t               ctrl_q;
  logic                req_q;
  logic                halt_q;
  logic [31:0]         ir_op;

  bip_control_mc_if #(.NB_OPCODE(NB_OPCODE)) dec_if ();

  // Decode the incoming word so the strobes are registered on entry to EXEC.
  assign dec_if.opcode = i_instr[NB_INSTR-1 -: NB_OPCODE];
  assign ir_op         = 32'(ir[NB_INSTR-1 -: NB_OPCODE]);

  bip_decoder u_decoder (.dec(dec_if.slave));

`ifdef BIP_CONTROL_MC_INSTR_CNT_EN
  logic [31:0] instr_cnt;
  assign o_instr_count = instr_cnt;
`endif

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state  <= ST_FETCH;
      pc     <= '0;
      ir     <= '0;
      ctrl_q <= '0;
      req_q  <= 1'b1;
      halt_q <= 1'b0;
`ifdef BIP_CONTROL_MC_INSTR_CNT_EN
      instr_cnt <= '0;
`endif
    end else if (i_enable) begin
      case (state)
        ST_FETCH: begin
          if (i_instr_valid) begin
            ir     <= i_instr;
            ctrl_q <= dec_if.ctrl;
            req_q  <= 1'b0;
            state  <= ST_EXEC;
          end
        end
        ST_EXEC: begin
`ifdef BIP_CONTROL_MC_INSTR_CNT_EN
          instr_cnt <= instr_cnt + 32'd1;
`endif
          ctrl_q <= '0;
          if (ir_op == OP_HLT) begin
            halt_q <= 1'b1;
            state  <= ST_HALT;
          end else begin
            pc <= pc + NB_PC'(1);
            if (ir_op == OP_LD) begin
              ctrl_q.wr_acc <= 1'b1;
              ctrl_q.sel_a  <= SEL_A_MEM;
              state         <= ST_LOAD_WAIT;
            end else begin
              req_q <= 1'b1;
              state <= ST_FETCH;
            end
          end
        end
        ST_LOAD_WAIT: begin
          ctrl_q <= '0;
          req_q  <= 1'b1;
          state  <= ST_FETCH;
        end
        default: begin
          ctrl_q <= '0;
          req_q  <= 1'b0;
        end
      endcase
    end
  end

  assign o_pc        = pc;
  assign o_operand   = NB_DATA'($signed(ir[NB_OPERAND-1:0]));
  assign o_instr_req = req_q & i_enable;
  assign o_wr_acc    = ctrl_q.wr_acc & i_enable;
  assign o_wr_ram    = ctrl_q.wr_ram & i_enable;
  assign o_rd_ram    = ctrl_q.rd_ram & i_enable;
  assign o_illegal   = ctrl_q.illegal & i_enable;
  assign o_sel_a     = ctrl_q.sel_a;
  assign o_sel_b     = ctrl_q.sel_b;
  assign o_op        = ctrl_q.op;
  assign o_halt      = halt_q;

endmodule

// File: tb/tb_bip_control_mc.sv
// Directed bench for bip_control_mc; expected values are hand-derived per instruction.
module tb_bip_control_mc;

  logic        i_clock = 1'b0;
  logic        i_reset;
  logic        i_enable;
  logic [15:0] i_instr;
  logic        i_instr_valid;
  logic [10:0] pc;
  logic        instr_req;
  logic [15:0] operand;
  logic [1:0]  sel_a;
  logic        sel_b;
  logic        op;
  logic        wr_acc;
  logic        wr_ram;
  logic        rd_ram;
  logic        halt;
  logic        illegal;
`ifdef BIP_CONTROL_MC_INSTR_CNT_EN
  logic [31:0] instr_count;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  always #5 i_clock = ~i_clock;

  bip_control_mc dut (
    .i_clock       (i_clock),
    .i_reset       (i_reset),
    .i_enable      (i_enable),
    .i_instr       (i_instr),
    .i_instr_valid (i_instr_valid),
    .o_pc          (pc),
    .o_instr_req   (instr_req),
    .o_operand     (operand),
    .o_sel_a       (sel_a),
    .o_sel_b       (sel_b),
    .o_op          (op),
    .o_wr_acc      (wr_acc),
    .o_wr_ram      (wr_ram),
    .o_rd_ram      (rd_ram),
    .o_halt        (halt),
    .o_illegal     (illegal)
`ifdef BIP_CONTROL_MC_INSTR_CNT_EN
    ,
    .o_instr_count (instr_count)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clock);
    #1;
  endtask

  function automatic logic [15:0] mk(input logic [4:0] opc, input logic [10:0] opd);
    return {opc, opd};
  endfunction

  initial begin
    int n;
    i_reset = 1'b1; i_enable = 1'b1; i_instr_valid = 1'b0; i_instr = '0;
    tick(); tick();
    i_reset = 1'b0;
    #1;
    check("rst_req", 32'(instr_req), 1);
    check("rst_pc", 32'(pc), 0);
    check("rst_strobes", {28'd0, wr_acc, wr_ram, rd_ram, illegal}, 0);
    check("rst_halt", 32'(halt), 0);
    check("rst_operand", 32'(operand), 0);
`ifdef BIP_CONTROL_MC_INSTR_CNT_EN
    check("rst_cnt", instr_count, 0);
`endif

    // LDI 5 with valid in the request cycle
    i_instr = mk(5'd3, 11'd5); i_instr_valid = 1'b1; #1;
    check("ldi_req", 32'(instr_req), 1);
    check("ldi_pc0", 32'(pc), 0);
    tick(); i_instr_valid = 1'b0; #1;
    check("ldi_wr_acc", 32'(wr_acc), 1);
    check("ldi_sel_a", 32'(sel_a), 1);
    check("ldi_operand", 32'(operand), 5);
    check("ldi_req_exec", 32'(instr_req), 0);
    tick();
    check("ldi_pc1", 32'(pc), 1);
    check("ldi_wr_acc_off", 32'(wr_acc), 0);

    // SUBI -1
    i_instr = mk(5'd7, 11'h7FF); i_instr_valid = 1'b1;
    tick(); i_instr_valid = 1'b0; #1;
    check("subi_operand", 32'(operand), 32'hFFFF);
    check("subi_ctl", {27'd0, wr_acc, sel_a, sel_b, op}, {27'd0, 1'b1, 2'b10, 1'b1, 1'b1});
    tick();
    check("subi_pc", 32'(pc), 2);

    // LD 3: EXEC reads, LOAD_WAIT writes acc
    i_instr = mk(5'd2, 11'd3); i_instr_valid = 1'b1;
    tick(); i_instr_valid = 1'b0; #1;
    check("ld_exec", {29'd0, rd_ram, wr_acc, instr_req}, {29'd0, 3'b100});
    tick();
    check("ld_wait", {28'd0, rd_ram, wr_acc, sel_a}, {28'd0, 4'b0100});
    check("ld_wait_req", 32'(instr_req), 0);
    tick();
    check("ld_fetch", {20'd0, instr_req, pc}, {20'd0, 1'b1, 11'd3});

    // STO 9
    i_instr = mk(5'd1, 11'd9); i_instr_valid = 1'b1;
    tick(); i_instr_valid = 1'b0; #1;
    check("sto_wr_ram", {29'd0, wr_ram, wr_acc, rd_ram}, {29'd0, 3'b100});
    tick();
    check("sto_pc", 32'(pc), 4);

    // ADD with valid delayed 3 cycles and enable dropped for 2 cycles mid-EXEC
    i_instr = mk(5'd4, 11'd1);
    for (int k = 0; k < 3; k++) begin
      check("wait_req", {20'd0, instr_req, pc}, {20'd0, 1'b1, 11'd4});
      tick();
    end
    i_instr_valid = 1'b1;
    tick(); i_instr_valid = 1'b0; #1;
    check("add_ctl", {28'd0, wr_acc, sel_a, op}, {28'd0, 1'b1, 2'b10, 1'b0});
    i_enable = 1'b0; #1;
    check("dis_strobe0", {30'd0, wr_acc, instr_req}, 0);
    tick();
    check("dis_strobe1", {30'd0, wr_acc, instr_req}, 0);
    check("dis_pc", 32'(pc), 4);
    tick();
    i_enable = 1'b1; #1;
    check("en_resume", 32'(wr_acc), 1);
    tick();
    check("add_pc", 32'(pc), 5);
    tick();
    check("add_once", {20'd0, instr_req, pc}, {20'd0, 1'b1, 11'd5});

    // Undefined opcode
    i_instr = mk(5'h1F, 11'd0); i_instr_valid = 1'b1;
    tick(); i_instr_valid = 1'b0; #1;
    check("ill_pulse", {28'd0, illegal, wr_acc, wr_ram, rd_ram}, {28'd0, 4'b1000});
    tick();
    check("ill_clear", 32'(illegal), 0);
    check("ill_pc", 32'(pc), 6);
`ifdef BIP_CONTROL_MC_INSTR_CNT_EN
    check("cnt_six", instr_count, 6);
`endif

    // SUB
    i_instr = mk(5'd6, 11'd0); i_instr_valid = 1'b1;
    tick(); i_instr_valid = 1'b0; #1;
    check("sub_ctl", {27'd0, wr_acc, sel_a, sel_b, op}, {27'd0, 1'b1, 2'b10, 1'b0, 1'b1});
    tick();
`ifdef BIP_CONTROL_MC_INSTR_CNT_EN
    check("cnt_seven", instr_count, 7);
`endif

    // Run ADDs to pc=2047, then ADD wraps to 0
    i_instr = mk(5'd4, 11'd0); i_instr_valid = 1'b1;
    n = 0;
    while (pc != 11'd2047 && n < 5000) begin tick(); n++; end
    check("reach_top_a", 32'(pc), 2047);
    tick(); tick();
    check("pc_wrap", 32'(pc), 0);

    // Back to 2047, then HLT
    n = 0;
    while (pc != 11'd2047 && n < 5000) begin tick(); n++; end
    check("reach_top_b", 32'(pc), 2047);
    i_instr = mk(5'd0, 11'd0);
    tick(); #1;
    check("hlt_exec", {29'd0, halt, wr_acc, wr_ram}, 0);
    tick();
    for (int k = 0; k < 3; k++) begin
      check("halt_state", {19'd0, halt, instr_req, pc}, {19'd0, 1'b1, 1'b0, 11'd2047});
      tick();
    end
    i_reset = 1'b1; i_instr_valid = 1'b0;
    tick();
    i_reset = 1'b0; #1;
    check("halt_reset", {19'd0, halt, instr_req, pc}, {19'd0, 1'b0, 1'b1, 11'd0});

    // Reset during LOAD_WAIT, with enable low
    i_instr = mk(5'd2, 11'd3); i_instr_valid = 1'b1;
    tick(); i_instr_valid = 1'b0;
    tick();
    check("ld_wait2", 32'(wr_acc), 1);
    i_reset = 1'b1; i_enable = 1'b0;
    tick();
    i_reset = 1'b0; i_enable = 1'b1; #1;
    check("ld_abort", {19'd0, wr_acc, instr_req, pc}, {19'd0, 1'b0, 1'b1, 11'd0});
`ifdef BIP_CONTROL_MC_INSTR_CNT_EN
    check("cnt_reset", instr_count, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/bip_control_mc.md
BIP_CONTROL_MC -- requirements
Module: bip_control_mc

Interface
REQ-001 SHALL have parameter NB_PC, default 11, program-counter width.
REQ-002 SHALL have parameter NB_OPCODE, default 5, opcode field width (instruction MSBs).
REQ-003 SHALL have parameter NB_OPERAND, default 11, operand field width (instruction LSBs).
REQ-004 SHALL have parameter NB_DATA, default 16, datapath width; operand is sign-extended to it.
REQ-005 SHALL have i_clock  in  1  sole clock, all state on rising edge.
REQ-006 SHALL have i_reset  in  1  synchronous, active-high reset.
REQ-007 SHALL have i_enable  in  1  low freezes all state and deasserts all strobes.
REQ-008 SHALL have i_instr  in  NB_OPCODE+NB_OPERAND  instruction word from program memory.
REQ-009 SHALL have i_instr_valid  in  1  i_instr is valid this cycle.
REQ-010 SHALL have o_pc  out  NB_PC  fetch address; o_instr_req  out  1  fetch request.
REQ-011 SHALL have o_operand  out  NB_DATA  sign-extended operand of the latched instruction.
REQ-012 SHALL have o_sel_a  out  2  accumulator source: 00 memory, 01 immediate, 10 ALU.
REQ-013 SHALL have o_sel_b  out  1  ALU B source: 0 memory, 1 immediate; o_op  out  1  0 add, 1 sub.
REQ-014 SHALL have o_wr_acc, o_wr_ram, o_rd_ram, o_halt, o_illegal  out  1 each.

Function
REQ-015 SHALL implement states FETCH, EXEC, LOAD_WAIT, HALT.
REQ-016 In FETCH: o_instr_req=1; on i_instr_valid latch i_instr into IR, go EXEC; else stay.
REQ-017 i_instr_valid outside FETCH SHALL be ignored.
REQ-018 In EXEC: decode IR; one-cycle strobes; o_pc increments modulo 2^NB_PC; next FETCH, except LD -> LOAD_WAIT and HLT -> HALT.
REQ-019 Opcodes: HLT 0, STO 1, LD 2, LDI 3, ADD 4, ADDI 5, SUB 6, SUBI 7.
REQ-020 STO: o_wr_ram=1. LDI: o_wr_acc=1, sel_a=01. ADD/SUB: wr_acc, sel_a=10, sel_b=0, op=0/1. ADDI/SUBI: same with sel_b=1.
REQ-021 LD: EXEC asserts o_rd_ram; LOAD_WAIT asserts o_wr_acc with sel_a=00 (sync RAM, 1-cycle latency), then FETCH.
REQ-022 Undefined opcode: o_illegal pulses in EXEC, no other strobe, PC increments.
REQ-023 HALT: o_halt=1, no request or strobes, PC held; left only by reset.
REQ-024 Strobes SHALL be zero in every state and case not listed above.
REQ-025 i_enable=0 in any state: state, PC and IR hold; all strobes and o_instr_req are 0.
REQ-026 Throughput: 2 cycles per instruction with valid in the request cycle; LD 3 cycles.
REQ-027 PC at 2^NB_PC-1 SHALL wrap to 0 without flag.

Reset
REQ-028 Reset: state FETCH, o_pc=0, IR=0, all strobes/o_halt/o_illegal 0; o_instr_req=1 in first post-reset cycle.
REQ-029 Reset SHALL override enable and abort any state, including LOAD_WAIT mid-load.

Configuration
REQ-030 With BIP_CONTROL_MC_INSTR_CNT_EN defined: add output o_instr_count (32 bits), incremented on each EXEC (HLT included), reset 0, held when disabled, wraps.
REQ-031 Without the macro: port absent, no counter logic.

Structure
REQ-032 Package bip_pkg SHALL hold opcode constants, sel_a/sel_b/op encodings and state encoding.
REQ-033 Combinational sub-module bip_decoder SHALL map opcode to control word; FSM, PC and IR in bip_control_mc.

Verification
REQ-034 Reset then LDI 5 with immediate valid -> cycle 1 o_instr_req=1 pc=0; cycle 2 wr_acc=1 sel_a=01 operand=5; pc=1.
REQ-035 SUBI 0x7FF (NB_OPERAND=11) -> o_operand=16'hFFFF, sel_b=1, op=1, wr_acc=1.
REQ-036 LD 3 -> EXEC rd_ram=1 wr_acc=0; next cycle wr_acc=1 sel_a=00; then FETCH pc+1.
REQ-037 Valid delayed 3 cycles and i_enable low 2 cycles mid-EXEC -> request held, strobes zero while disabled, one execution only.
REQ-038 HLT at pc=2047 -> o_halt=1 permanently, pc stays 2047; reset -> pc=0; separately ADD at 2047 -> pc wraps to 0.
REQ-039 Opcode 5'h1F -> o_illegal one cycle, no writes; with macro, count increments by 1 per EXEC.
